pcr_restamp: RTL and testbench
==============================

Name: pcr_restamp

Overview:
- Inline MPEG-2 transport-stream byte processor.
- Detects PCR-bearing packets.
- Adds a signed offset, in 27 MHz ticks, to each PCR.
- Passes all other bytes through bit-exact after a fixed 12-byte pipeline.
- Sits after the TS source / mux, before the QAM output path, in a single clock domain.

Parameters:
- PCR_OFFSET, default 0: signed 32-bit correction in 27 MHz ticks. Legal range is -2^24 to +2^24.

Ports:
- clk  in  1  byte clock.
- rst_n  in  1  asynchronous, active-low reset.
- ts_sync  in  1  marks first byte (0x47) of a packet; qualified by ts_valid.
- ts_valid  in  1  input byte strobe; gaps allowed.
- ts_data  in  8  input byte.
- pcr_correct_ena  in  1  1 = restamp PCR, 0 = pure passthrough.
- ts_o_sync  out  1  first byte of output packet.
- ts_o_valid  out  1  output byte strobe.
- ts_o_data  out  8  output byte.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, pipeline emptied, byte counter 0.
- Pipeline:
  - 12-stage byte shift register (data + sync flag per stage) plus an occupancy count.
  - It advances only on ts_valid.
  - When ts_valid=1 and all 12 stages are occupied, stage 11 is registered to the outputs the next cycle with ts_o_valid=1. Otherwise ts_o_valid=0.
  - Latency is exactly 12 valid input bytes plus one clock.
  - Bytes stay in the pipeline until more input arrives; there is no flush.
- Byte counter:
  - Cleared to 0 by ts_valid & ts_sync.
  - Incremented per valid byte; saturates at 12.
  - Bytes before the first sync pass through unmodified.
- PCR detection, evaluated in the cycle byte index 11 is accepted (byte 0 is then in stage 11). All of the following must hold:
  - byte0 = 0x47.
  - byte1 bit7 (transport_error) = 0.
  - byte3 bits[5:4] is 2'b10 or 2'b11.
  - byte4 (adaptation_field_length) >= 7.
  - byte5 bit4 (PCR_flag) = 1.
  - pcr_correct_ena = 1.
- PCR field layout, bytes 6..11: base[32:0], 6 reserved bits, ext[8:0].
- Correction arithmetic:
  - T = base*300 + ext.
  - T' = (T + offset) mod (2^33 * 300); negative results wrap upward.
  - Output base' = T' div 300, ext' = T' mod 300.
  - Reserved bits are rewritten as 6'b111111.
  - Stages holding bytes 6..11 are overwritten in that same cycle, before they shift.
- A new sync before byte 11 (short packet) restarts the counter; the partial packet passes unmodified.
- ts_o_sync is the delayed sync flag; it is never regenerated.
- pcr_correct_ena=0: output is identical to input, same latency.

Optional Feature:
- Macro PCR_OFFSET_PORT_EN.
- When defined: adds input port pcr_offset [31:0] (signed ticks). It is sampled at the byte-11 cycle and replaces PCR_OFFSET.
- When undefined: the port is absent and the offset is the parameter constant.

Decomposition:
- Package pcr_pkg holds:
  - TS_SYNC_BYTE = 8'h47.
  - PCR_EXT_MOD = 300.
  - PCR_BASE_W = 33, PCR_EXT_W = 9.
  - PCR_HDR_BYTES = 12.
- One sub-module, pcr_add: purely combinational.
  - Inputs: base, ext, offset.
  - Outputs: base', ext'.
  - Implements mod-300 ext carry/borrow, then mod-2^33 base wrap.
  - Offset is pre-split into base and ext parts by div/mod 300.
- The stimulus generator ts_gen is a bench-only model and is not part of the RTL.

Test Plan:
- 188-byte packet, AFC=2'b11, AF len 7, PCR_flag=1, base=0, ext=299, offset=+1 → output base=1, ext=0, reserved=6'h3F, all other bytes unchanged.
- base=2^33-1, ext=299, offset=+1 → base=0, ext=0. Then base=0, ext=0, offset=-1 → base=2^33-1, ext=299.
- PCR_flag=0, AFC=2'b01, or transport_error=1, or pcr_correct_ena=0 → every byte bit-exact; first output byte appears one clock after the 13th valid input byte.
- Random ts_valid gaps (50% duty) with offset=+600 → base increments by 2, ext unchanged. ts_o_valid count equals input valid count minus 12.
- Sync asserted again at byte 8 → truncated packet passes unmodified; next full packet is corrected.
- rst_n pulsed low mid-packet → outputs 0 immediately; after release, bytes before the next sync pass unmodified.

Source files
------------

// File: rtl/pcr_restamp_pkg.sv
// Shared constants and the PCR field layout for the pcr_restamp slice.
package pcr_pkg;
  localparam logic [7:0]  TS_SYNC_BYTE  = 8'h47;
  localparam int unsigned PCR_EXT_MOD   = 300;
  localparam int          PCR_BASE_W    = 33;
  localparam int          PCR_EXT_W     = 9;
  localparam int          PCR_HDR_BYTES = 12;

  typedef struct packed {
    logic [PCR_BASE_W-1:0] base;
    logic [5:0]            rsvd;
    logic [PCR_EXT_W-1:0]  ext;
  } pcr_field_t;
endpackage

// File: rtl/pcr_restamp_add.sv
// Combinational PCR adder: splits the tick offset into base/ext parts, carries ext mod 300,
// then wraps base mod 2^33.
module pcr_add
  import pcr_pkg::*;
(
  input  logic [PCR_BASE_W-1:0] base,
  input  logic [PCR_EXT_W-1:0]  ext,
  input  logic [31:0]           offset,
  output logic [PCR_BASE_W-1:0] base_o,
  output logic [PCR_EXT_W-1:0]  ext_o
);
  logic [31:0]           mag;
  logic [31:0]           q;
  logic [8:0]            r;
  logic [PCR_BASE_W-1:0] off_base;
  logic [PCR_EXT_W-1:0]  off_ext;
  logic [31:0]           sum;

  always_comb begin
    mag = offset[31] ? (~offset + 32'd1) : offset;
    q   = mag / PCR_EXT_MOD;
    r   = 9'(mag % PCR_EXT_MOD);
    // Floor division for negative offsets keeps off_ext in 0..299.
    if (!offset[31]) begin
      off_base = 33'(q);
      off_ext  = r;
    end else if (r == 9'd0) begin
      off_base = ~33'(q) + 33'd1;
      off_ext  = '0;
    end else begin
      off_base = ~33'(q);
      off_ext  = 9'(PCR_EXT_MOD - 32'(r));
    end
    sum    = 32'(ext) + 32'(off_ext);
    ext_o  = 9'(sum % PCR_EXT_MOD);
    base_o = base + off_base + 33'(sum / PCR_EXT_MOD);
  end
endmodule

// File: rtl/pcr_restamp.sv
// Inline TS byte pipeline (12 bytes) that adds a tick offset to PCR fields.
// Optional macro PCR_OFFSET_PORT_EN adds a run-time pcr_offset input replacing PCR_OFFSET.
module pcr_restamp
  import pcr_pkg::*;
#(
  parameter int PCR_OFFSET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ts_sync,
  input  logic       ts_valid,
  input  logic [7:0] ts_data,
  input  logic       pcr_correct_ena,
`ifdef PCR_OFFSET_PORT_EN
  input  logic [31:0] pcr_offset,
`endif
  output logic       ts_o_sync,
  output logic       ts_o_valid,
  output logic [7:0] ts_o_data
);
  logic [7:0]            stg_data [PCR_HDR_BYTES];
  logic                  stg_sync [PCR_HDR_BYTES];
  logic [7:0]            nxt_data [PCR_HDR_BYTES];
  logic [3:0]            occ;
  logic [3:0]            cnt;
  logic                  hit;
  logic [31:0]           offset;
  logic [PCR_BASE_W-1:0] base_in, base_out;
  logic [PCR_EXT_W-1:0]  ext_in, ext_out;
  pcr_field_t            fld;

`ifdef PCR_OFFSET_PORT_EN
  assign offset = pcr_offset;
`else
  assign offset = PCR_OFFSET;
`endif

  // Byte 0 sits in stage 11, so PCR bytes 6..11 occupy stages 5..0.
  assign base_in = {stg_data[5], stg_data[4], stg_data[3], stg_data[2], stg_data[1][7]};
  assign ext_in  = {stg_data[1][0], stg_data[0]};

  pcr_add u_add (
    .base   (base_in),
    .ext    (ext_in),
    .offset (offset),
    .base_o (base_out),
    .ext_o  (ext_out)
  );

  assign hit = ts_valid && pcr_correct_ena && (cnt == 4'(PCR_HDR_BYTES - 1)) && stg_sync[11]
            && (stg_data[11] == TS_SYNC_BYTE) && !stg_data[10][7] && stg_data[8][5]
            && (stg_data[7] >= 8'd7) && stg_data[6][4];

  always_comb begin
    fld.base = base_out;
    fld.rsvd = 6'h3F;
    fld.ext  = ext_out;
    for (int i = 0; i < PCR_HDR_BYTES; i++) nxt_data[i] = stg_data[i];
    if (hit) begin
      for (int j = 0; j < 6; j++) nxt_data[j] = fld[8*j +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PCR_HDR_BYTES; i++) begin
        stg_data[i] <= '0;
        stg_sync[i] <= 1'b0;
      end
      occ        <= '0;
      cnt        <= '0;
      ts_o_sync  <= 1'b0;
      ts_o_valid <= 1'b0;
      ts_o_data  <= '0;
    end else begin
      ts_o_valid <= 1'b0;
      ts_o_sync  <= 1'b0;
      if (ts_valid) begin
        stg_data[0] <= ts_data;
        stg_sync[0] <= ts_sync;
        for (int i = 1; i < PCR_HDR_BYTES; i++) begin
          stg_data[i] <= nxt_data[i-1];
          stg_sync[i] <= stg_sync[i-1];
        end
        if (occ == 4'(PCR_HDR_BYTES)) begin
          ts_o_valid <= 1'b1;
          ts_o_sync  <= stg_sync[11];
          ts_o_data  <= nxt_data[11];
        end else begin
          occ <= occ + 4'd1;
        end
        if (ts_sync) cnt <= '0;
        else if (cnt != 4'(PCR_HDR_BYTES)) cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_pcr_restamp.sv
// Bench for pcr_restamp: three instances (offsets +1, -1, +600) share one stimulus stream
// and are checked against a packet-level tick-arithmetic reference.
module tb_pcr_restamp;
  typedef struct { logic [7:0] d; logic s; } ib_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ts_sync = 1'b0;
  logic       ts_valid = 1'b0;
  logic [7:0] ts_data = 8'h00;
  logic       ena = 1'b0;
  logic       o_sync [3];
  logic       o_valid [3];
  logic [7:0] o_data [3];

  int   offs [3] = '{1, -1, 600};
  ib_t  stim [$];
  ib_t  expq [$];
  ib_t  oq [3][$];
  int   first_cyc [3];
  int   cyc = 0;
  int   n_in = 0;
  int   lat_cyc = -1;
  bit   gaps_on = 1'b0;
  int   checks = 0;
  int   errors = 0;
  localparam longint M = longint'(300) << 33;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcr_restamp #(.PCR_OFFSET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_data(ts_data),
    .pcr_correct_ena(ena),
`ifdef PCR_OFFSET_PORT_EN
    .pcr_offset(32'd1),
`endif
    .ts_o_sync(o_sync[0]), .ts_o_valid(o_valid[0]), .ts_o_data(o_data[0]));

  pcr_restamp #(.PCR_OFFSET(-1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_data(ts_data),
    .pcr_correct_ena(ena),
`ifdef PCR_OFFSET_PORT_EN
    .pcr_offset(32'hFFFF_FFFF),
`endif
    .ts_o_sync(o_sync[1]), .ts_o_valid(o_valid[1]), .ts_o_data(o_data[1]));

  pcr_restamp #(.PCR_OFFSET(600)) dut2 (
    .clk(clk), .rst_n(rst_n), .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_data(ts_data),
    .pcr_correct_ena(ena),
`ifdef PCR_OFFSET_PORT_EN
    .pcr_offset(32'd600),
`endif
    .ts_o_sync(o_sync[2]), .ts_o_valid(o_valid[2]), .ts_o_data(o_data[2]));

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (o_valid[k]) begin
          if (oq[k].size() == 0) first_cyc[k] = cyc;
          oq[k].push_back('{d: o_data[k], s: o_sync[k]});
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pack(input logic [32:0] base, input logic [8:0] ext);
    return {base, 6'h3F, ext};
  endfunction

  task automatic add_pkt(input logic tei, input logic [1:0] afc, input logic [7:0] aflen,
                         input logic pflag, input logic [32:0] base, input logic [8:0] ext,
                         input int len, input logic sync_flag);
    logic [7:0]  b [188];
    logic [47:0] w;
    for (int i = 0; i < 188; i++) b[i] = 8'($urandom);
    b[0] = 8'h47;
    b[1] = {tei, b[1][6:0]};
    b[3] = {2'b00, afc, b[3][3:0]};
    b[4] = aflen;
    b[5] = {3'b000, pflag, b[5][3:0]};
    w = {base, 6'($urandom), ext};
    for (int j = 0; j < 6; j++) b[6+j] = w[8*(5-j) +: 8];
    for (int i = 0; i < len; i++) stim.push_back('{d: b[i], s: (i == 0) ? sync_flag : 1'b0});
  endtask

  // Reference: packet starts only at a sync-flagged byte with 11 following non-sync bytes.
  function automatic bit hdr_ok(input int i);
    for (int j = 1; j < 12; j++) if (stim[i+j].s) return 1'b0;
    return ena && stim[i].d == 8'h47 && stim[i+1].d[7] == 1'b0
        && (stim[i+3].d[5:4] == 2'b10 || stim[i+3].d[5:4] == 2'b11)
        && stim[i+4].d >= 8'd7 && stim[i+5].d[4] == 1'b1;
  endfunction

  function automatic void model(input int off);
    longint word, t, nw;
    expq = stim;
    for (int i = 0; i + 11 < stim.size(); i++) begin
      if (stim[i].s && hdr_ok(i)) begin
        word = 0;
        for (int j = 0; j < 6; j++) word = (word << 8) | longint'(stim[i+6+j].d);
        t = (word >> 15) * 300 + (word & 511) + longint'(off);
        t = t % M;
        if (t < 0) t = t + M;
        nw = ((t / 300) << 15) | (longint'(63) << 9) | (t % 300);
        for (int j = 0; j < 6; j++) expq[i+6+j].d = 8'(nw >> (8 * (5 - j)));
      end
    end
  endfunction

  function automatic logic [47:0] get_pcr(input int k, input int idx);
    logic [47:0] w = '0;
    if (oq[k].size() < idx + 12) return '0;
    for (int j = 0; j < 6; j++) w = {w[39:0], oq[k][idx+6+j].d};
    return w;
  endfunction

  task automatic drive(input logic [7:0] d, input logic s);
    @(negedge clk);
    while (gaps_on && $urandom_range(1, 0) == 0) begin
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      @(negedge clk);
    end
    ts_valid = 1'b1;
    ts_data  = d;
    ts_sync  = s;
    n_in++;
    if (n_in == 13) lat_cyc = cyc + 1;
  endtask

  task automatic send_all();
    for (int i = 0; i < stim.size(); i++) drive(stim[i].d, stim[i].s);
    @(negedge clk);
    ts_valid = 1'b0;
    ts_sync  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_bench();
    for (int k = 0; k < 3; k++) begin
      oq[k].delete();
      first_cyc[k] = -1;
    end
    stim.delete();
    n_in = 0;
    lat_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ts_valid = 1'b0;
    ts_sync = 1'b0;
    ts_data = 8'h00;
    @(negedge clk);
    clear_bench();
    rst_n = 1'b1;
  endtask

  task automatic compare_phase(input string ph);
    for (int k = 0; k < 3; k++) begin
      model(offs[k]);
      chk($sformatf("%s dut%0d count", ph, k), 64'(oq[k].size()), 64'(stim.size() - 12));
      for (int i = 0; i < stim.size() - 12 && i < oq[k].size(); i++)
        chk($sformatf("%s dut%0d byte%0d", ph, k, i), {55'd0, oq[k][i].s, oq[k][i].d},
            {55'd0, expq[i].s, expq[i].d});
    end
  endtask

  task automatic check_zero(input string ph);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s dut%0d outputs", ph, k), {54'd0, o_sync[k], o_valid[k], o_data[k]}, 64'd0);
  endtask

  initial begin
    logic [32:0] rb;
    logic [8:0]  re;
    for (int k = 0; k < 3; k++) first_cyc[k] = -1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // A: corrections incl. wrap both ways, continuous input, latency
    do_reset();
    ena = 1'b1;
    gaps_on = 1'b0;
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd0, 9'd299, 188, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, {33{1'b1}}, 9'd299, 188, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd0, 9'd0, 188, 1'b1);
    send_all();
    compare_phase("A");
    chk("A latency", 64'(first_cyc[0]), 64'(lat_cyc));
    chk("A +1 carry", get_pcr(0, 0), pack(33'd1, 9'd0));
    chk("A +1 wrap", get_pcr(0, 188), pack(33'd0, 9'd0));
    chk("A -1 borrow", get_pcr(1, 0), pack(33'd0, 9'd298));
    chk("A -1 wrap", get_pcr(1, 376), pack({33{1'b1}}, 9'd299));
    chk("A +600", get_pcr(2, 0), pack(33'd2, 9'd299));

    // B: 50% valid gaps, mix of qualifying and non-qualifying headers
    do_reset();
    gaps_on = 1'b1;
    rb = {1'($urandom), 32'($urandom)};
    re = 9'($urandom_range(299, 0));
    add_pkt(1'b0, 2'b10, 8'd183, 1'b1, rb, re, 188, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b0, {1'($urandom), 32'($urandom)}, 9'd5, 188, 1'b1);
    add_pkt(1'b0, 2'b01, 8'd7, 1'b1, {1'($urandom), 32'($urandom)}, 9'd6, 188, 1'b1);
    add_pkt(1'b1, 2'b11, 8'd7, 1'b1, {1'($urandom), 32'($urandom)}, 9'd7, 188, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd6, 1'b1, {1'($urandom), 32'($urandom)}, 9'd8, 188, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, {1'($urandom), 32'($urandom)}, 9'($urandom_range(299, 0)), 188, 1'b1);
    send_all();
    compare_phase("B");
    chk("B +600 gaps", get_pcr(2, 0), pack(rb + 33'd2, re));

    // C: correction disabled -> bit-exact
    do_reset();
    gaps_on = 1'b0;
    ena = 1'b0;
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd0, 9'd299, 188, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd12345, 9'd1, 188, 1'b1);
    send_all();
    compare_phase("C");
    chk("C latency", 64'(first_cyc[0]), 64'(lat_cyc));
    chk("C untouched", get_pcr(0, 0), {stim[6].d, stim[7].d, stim[8].d, stim[9].d, stim[10].d, stim[11].d});

    // D: short packet (sync again at byte 8) then a full packet
    do_reset();
    ena = 1'b1;
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd100, 9'd0, 8, 1'b1);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd200, 9'd299, 188, 1'b1);
    send_all();
    compare_phase("D");
    chk("D full pkt", get_pcr(0, 8), pack(33'd201, 9'd0));

    // E: async reset mid-packet, then pre-sync lookalike bytes must pass untouched
    do_reset();
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd7, 9'd7, 188, 1'b1);
    for (int i = 0; i < 30; i++) drive(stim[i].d, stim[i].s);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("E async reset");
    @(negedge clk);
    ts_valid = 1'b0;
    ts_sync = 1'b0;
    @(negedge clk);
    clear_bench();
    rst_n = 1'b1;
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd50, 9'd299, 20, 1'b0);
    add_pkt(1'b0, 2'b11, 8'd7, 1'b1, 33'd60, 9'd299, 188, 1'b1);
    send_all();
    compare_phase("E");
    chk("E pre-sync", get_pcr(0, 0), {stim[6].d, stim[7].d, stim[8].d, stim[9].d, stim[10].d, stim[11].d});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
